// File: rtl/instr_encoder.sv
// Packs a decoded instruction into one or two 32-bit words behind a valid/ready handshake.
// Optional short-immediate RRI form is compiled in when INSTR_ENC_SHORT_IMM_EN is defined.
module instr_encoder #(
    parameter int unsigned SHIFT_TYPE_W = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2:0]              in_kind,
    input  logic [2:0]              in_cond,
    input  logic [4:0]              in_op,
    input  logic [4:0]              in_rd,
    input  logic [4:0]              in_rs,
    input  logic [4:0]              in_rq,
    input  logic [31:0]             in_imm,
    input  logic [SHIFT_TYPE_W-1:0] in_shift_type,
    input  logic [4:0]              in_shift_amt,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_word,
    output logic                    out_last,
    output logic                    enc_err
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned ST_W   = 2;

    localparam logic [2:0] K_RRR    = 3'd0;
    localparam logic [2:0] K_MEMORY = 3'd1;
    localparam logic [2:0] K_RRI    = 3'd3;
    localparam logic [2:0] K_CUSTOM = 3'd4;
    localparam logic [4:0] OP_BAD   = 5'd31;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_W0   = 2'd1;
    localparam logic [1:0] S_W1   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [WORD_W-1:0] word1_q, word1_d;
    logic              ext_q, ext_d;
    logic              out_valid_d, out_last_d, enc_err_d;
    logic [WORD_W-1:0] out_word_d;

    logic              reject_c, short_c, ext_c;
    logic [4:0]        rq_field_c;
    logic [ST_W-1:0]   st_field_c;
    logic [WORD_W-1:0] word0_c, word1_c;

    // Field packing of the incoming instruction, used only on acceptance
    always_comb begin
        reject_c = (in_kind > K_CUSTOM) || (in_op == OP_BAD);
`ifdef INSTR_ENC_SHORT_IMM_EN
        // Sign-fits in 5 bits: bits [31:4] are all copies of the sign
        short_c = (in_kind == K_RRI) && ((&in_imm[31:4]) || !(|in_imm[31:4]));
`else
        short_c = 1'b0;
`endif
        ext_c = ((in_kind == K_RRI) && !short_c)
             || ((in_kind == K_MEMORY) && (in_op >= 5'd6) && (in_op <= 5'd11))
             || ((in_kind == K_RRR) && (in_shift_amt != 5'd0));
        if (short_c) begin
            rq_field_c = in_imm[4:0];
        end else if (in_kind == K_RRI) begin
            rq_field_c = 5'd0;
        end else begin
            rq_field_c = in_rq;
        end
        st_field_c = ST_W'(in_shift_type);
        word0_c = {in_kind, in_cond, in_op, in_rd, in_rs, rq_field_c,
                   st_field_c, ext_c, short_c, 2'b00};
        word1_c = (in_kind == K_RRR) ? WORD_W'(in_shift_amt) : in_imm;
    end

    assign in_ready = (state_q == S_IDLE);

    // Next-state and next-output logic; outputs are registered below
    always_comb begin
        state_d     = state_q;
        word1_d     = word1_q;
        ext_d       = ext_q;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        out_word_d  = '0;
        enc_err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (reject_c) begin
                        enc_err_d = 1'b1;
                    end else begin
                        state_d     = S_W0;
                        word1_d     = word1_c;
                        ext_d       = ext_c;
                        out_valid_d = 1'b1;
                        out_word_d  = word0_c;
                        out_last_d  = !ext_c;
                    end
                end
            end
            S_W0: begin
                out_valid_d = 1'b1;
                out_word_d  = out_word;
                out_last_d  = out_last;
                if (out_ready) begin
                    if (ext_q) begin
                        state_d    = S_W1;
                        out_word_d = word1_q;
                        out_last_d = 1'b1;
                    end else begin
                        state_d     = S_IDLE;
                        out_valid_d = 1'b0;
                        out_word_d  = '0;
                        out_last_d  = 1'b0;
                    end
                end
            end
            S_W1: begin
                out_valid_d = 1'b1;
                out_word_d  = out_word;
                out_last_d  = 1'b1;
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    out_word_d  = '0;
                    out_last_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            word1_q   <= '0;
            ext_q     <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_word  <= '0;
            enc_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            word1_q   <= word1_d;
            ext_q     <= ext_d;
            out_valid <= out_valid_d;
            out_last  <= out_last_d;
            out_word  <= out_word_d;
            enc_err   <= enc_err_d;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vectors, reset-in-flight and randomized
// instructions compared against an arithmetic reference model.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_kind = '0;
    logic [2:0]  in_cond = '0;
    logic [4:0]  in_op = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_rs = '0;
    logic [4:0]  in_rq = '0;
    logic [31:0] in_imm = '0;
    logic [1:0]  in_shift_type = '0;
    logic [4:0]  in_shift_amt = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_word;
    logic        out_last;
    logic        enc_err;

    int n_checks = 0;
    int n_fail   = 0;

    instr_encoder #(.SHIFT_TYPE_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_cond(in_cond), .in_op(in_op),
        .in_rd(in_rd), .in_rs(in_rs), .in_rq(in_rq), .in_imm(in_imm),
        .in_shift_type(in_shift_type), .in_shift_amt(in_shift_amt),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_word(out_word), .out_last(out_last), .enc_err(enc_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: words computed from the field layout with plain arithmetic
    function automatic void model(input logic [2:0] kind, input logic [2:0] cond,
                                  input logic [4:0] op, input logic [4:0] rd,
                                  input logic [4:0] rs, input logic [4:0] rq,
                                  input logic [31:0] imm, input logic [1:0] st,
                                  input logic [4:0] sa, output int n,
                                  output logic [31:0] w0, output logic [31:0] w1);
        int     k;
        longint simm;
        bit     sh;
        bit     ext;
        int     rqf;
        k    = int'(kind);
        simm = longint'($signed(imm));
        sh   = 1'b0;
`ifdef INSTR_ENC_SHORT_IMM_EN
        sh = (k == 3) && (simm >= -16) && (simm <= 15);
`endif
        ext = ((k == 3) && !sh) || ((k == 1) && (op >= 5'd6) && (op <= 5'd11))
           || ((k == 0) && (sa != 5'd0));
        if (sh)          rqf = int'(imm[4:0]);
        else if (k == 3) rqf = 0;
        else             rqf = int'(rq);
        w0 = 32'(k) * 32'h2000_0000 + 32'(cond) * 32'h0400_0000 + 32'(op) * 32'h0020_0000
           + 32'(rd) * 32'h0001_0000 + 32'(rs) * 32'h0000_0800 + 32'(rqf) * 32'h40
           + 32'(st) * 32'h10 + (ext ? 32'd8 : 32'd0) + (sh ? 32'd4 : 32'd0);
        w1 = (k == 0) ? 32'(sa) : imm;
        n  = ((k >= 5) || (op == 5'd31)) ? 0 : (ext ? 2 : 1);
    endfunction

    // Drive one instruction and check every emitted word; stall0 < 0 means random word0 stall
    task automatic run_exp(input string tag, input logic [2:0] kind, input logic [2:0] cond,
                           input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs,
                           input logic [4:0] rq, input logic [31:0] imm, input logic [1:0] st,
                           input logic [4:0] sa, input int stall0, input int n,
                           input logic [31:0] w0, input logic [31:0] w1);
        int stalls;
        @(negedge clk);
        in_kind = kind; in_cond = cond; in_op = op; in_rd = rd; in_rs = rs; in_rq = rq;
        in_imm = imm; in_shift_type = st; in_shift_amt = sa;
        in_valid = 1'b1;
        check({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        // Scramble inputs so the encoder must rely on its captured copy
        in_imm = $urandom; in_rd = 5'($urandom); in_kind = 3'($urandom); in_op = 5'($urandom);
        in_shift_amt = 5'($urandom);
        if (n == 0) begin
            check({tag, " enc_err pulse"}, 32'(enc_err), 32'd1);
            check({tag, " reject out_valid"}, 32'(out_valid), 32'd0);
            @(negedge clk);
            check({tag, " enc_err clear"}, 32'(enc_err), 32'd0);
            check({tag, " reject out_valid2"}, 32'(out_valid), 32'd0);
        end else begin
            for (int i = 0; i < n; i++) begin
                if (i == 0 && stall0 >= 0) stalls = stall0;
                else                       stalls = int'($urandom_range(2, 0));
                for (int s = 0; s <= stalls; s++) begin
                    check({tag, $sformatf(" w%0d valid", i)}, 32'(out_valid), 32'd1);
                    check({tag, $sformatf(" w%0d word", i)}, out_word, (i == 0) ? w0 : w1);
                    check({tag, $sformatf(" w%0d last", i)}, 32'(out_last), (i == n - 1) ? 32'd1 : 32'd0);
                    check({tag, $sformatf(" w%0d in_ready", i)}, 32'(in_ready), 32'd0);
                    out_ready = (s == stalls);
                    @(negedge clk);
                end
                out_ready = 1'b0;
            end
        end
        check({tag, " end out_valid"}, 32'(out_valid), 32'd0);
        check({tag, " end out_word"}, out_word, 32'd0);
        check({tag, " end out_last"}, 32'(out_last), 32'd0);
        check({tag, " end in_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run_model(input string tag, input logic [2:0] kind, input logic [2:0] cond,
                             input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs,
                             input logic [4:0] rq, input logic [31:0] imm, input logic [1:0] st,
                             input logic [4:0] sa);
        int          n;
        logic [31:0] w0, w1;
        model(kind, cond, op, rd, rs, rq, imm, st, sa, n, w0, w1);
        run_exp(tag, kind, cond, op, rd, rs, rq, imm, st, sa, -1, n, w0, w1);
    endtask

    initial begin
        logic [2:0]  rk;
        logic [4:0]  rop;
        logic [31:0] rimm;
        logic [4:0]  rsa;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        check("post-rst out_valid", 32'(out_valid), 32'd0);
        check("post-rst out_last", 32'(out_last), 32'd0);
        check("post-rst out_word", out_word, 32'd0);
        check("post-rst enc_err", 32'(enc_err), 32'd0);
        check("post-rst in_ready", 32'(in_ready), 32'd1);

        // Reference vectors
        run_exp("rrr_add", 3'd0, 3'd0, 5'd0, 5'd1, 5'd2, 5'd3, 32'd0, 2'd0, 5'd0, 0,
                1, 32'h000110C0, 32'd0);
        run_exp("rri_sub_stall", 3'd3, 3'd1, 5'd1, 5'd4, 5'd5, 5'd9, 32'h12345678, 2'd0, 5'd0, 5,
                2, 32'h64242808, 32'h12345678);
`ifdef INSTR_ENC_SHORT_IMM_EN
        run_exp("rri_short", 3'd3, 3'd0, 5'd0, 5'd1, 5'd1, 5'd0, 32'hFFFFFFFD, 2'd0, 5'd0, 0,
                1, 32'h60010F44, 32'd0);
`else
        run_exp("rri_long", 3'd3, 3'd0, 5'd0, 5'd1, 5'd1, 5'd0, 32'hFFFFFFFD, 2'd0, 5'd0, 0,
                2, 32'h60010808, 32'hFFFFFFFD);
`endif
        run_exp("kind7", 3'd7, 3'd0, 5'd0, 5'd1, 5'd2, 5'd3, 32'd0, 2'd0, 5'd0, 0, 0, 32'd0, 32'd0);
        run_exp("rrr_after_err", 3'd0, 3'd0, 5'd0, 5'd1, 5'd2, 5'd3, 32'd0, 2'd0, 5'd0, 0,
                1, 32'h000110C0, 32'd0);

        // Boundaries handled by the model
        run_model("kind5", 3'd5, 3'd2, 5'd3, 5'd1, 5'd1, 5'd1, 32'd7, 2'd1, 5'd0);
        run_model("kind6", 3'd6, 3'd2, 5'd3, 5'd1, 5'd1, 5'd1, 32'd7, 2'd1, 5'd0);
        run_model("op31", 3'd0, 3'd2, 5'd31, 5'd1, 5'd1, 5'd1, 32'd7, 2'd1, 5'd0);
        run_model("mem_op5", 3'd1, 3'd4, 5'd5, 5'd7, 5'd8, 5'd9, 32'hCAFE0001, 2'd2, 5'd0);
        run_model("mem_op6", 3'd1, 3'd4, 5'd6, 5'd7, 5'd8, 5'd9, 32'hCAFE0002, 2'd2, 5'd0);
        run_model("mem_op11", 3'd1, 3'd4, 5'd11, 5'd7, 5'd8, 5'd9, 32'hCAFE0003, 2'd3, 5'd0);
        run_model("mem_op12", 3'd1, 3'd4, 5'd12, 5'd7, 5'd8, 5'd9, 32'hCAFE0004, 2'd3, 5'd0);
        run_model("rrr_shift31", 3'd0, 3'd7, 5'd2, 5'd31, 5'd30, 5'd29, 32'd0, 2'd3, 5'd31);
        run_model("rri_imm15", 3'd3, 3'd1, 5'd2, 5'd3, 5'd4, 5'd5, 32'd15, 2'd0, 5'd0);
        run_model("rri_imm16", 3'd3, 3'd1, 5'd2, 5'd3, 5'd4, 5'd5, 32'd16, 2'd0, 5'd0);
        run_model("rri_immm16", 3'd3, 3'd1, 5'd2, 5'd3, 5'd4, 5'd5, 32'hFFFFFFF0, 2'd0, 5'd0);
        run_model("rri_immm17", 3'd3, 3'd1, 5'd2, 5'd3, 5'd4, 5'd5, 32'hFFFFFFEF, 2'd0, 5'd0);
        run_model("model_kind", 3'd2, 3'd5, 5'd9, 5'd1, 5'd2, 5'd3, 32'hFFFF0000, 2'd1, 5'd4);

        // Reset while the extension word is on the bus
        @(negedge clk);
        in_kind = 3'd3; in_cond = 3'd1; in_op = 5'd1; in_rd = 5'd4; in_rs = 5'd5; in_rq = 5'd0;
        in_imm = 32'h12345678; in_shift_type = 2'd0; in_shift_amt = 5'd0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("rstw1 word0", out_word, 32'h64242808);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("rstw1 in W1 valid", 32'(out_valid), 32'd1);
        check("rstw1 in W1 word", out_word, 32'h12345678);
        rst_n = 1'b0;
        #1;
        check("rstw1 async valid", 32'(out_valid), 32'd0);
        check("rstw1 async word", out_word, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check("rstw1 in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("rstw1 no residual %0d", c), 32'(out_valid), 32'd0);
        end
        out_ready = 1'b0;
        run_model("post_rst_rrr", 3'd0, 3'd3, 5'd4, 5'd6, 5'd7, 5'd8, 32'd0, 2'd2, 5'd0);

        // Randomized instructions
        for (int t = 0; t < 60; t++) begin
            rk   = 3'($urandom_range(7, 0));
            rop  = ($urandom_range(9, 0) == 0) ? 5'd31 : 5'($urandom_range(15, 0));
            rimm = ($urandom_range(1, 0) == 1) ? 32'(int'($urandom_range(40, 0)) - 20) : $urandom;
            rsa  = ($urandom_range(1, 0) == 1) ? 5'd0 : 5'($urandom);
            run_model($sformatf("rand%0d", t), rk, 3'($urandom), rop, 5'($urandom), 5'($urandom),
                      5'($urandom), rimm, 2'($urandom), rsa);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
